// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: accumulates matching synaptic weights, leaks on tick,
// fires a one-cycle registered spike at threshold, then holds a fixed refractory period.
module lif_neuron #(
    parameter logic [6:0]         MY_ID          = 7'd0,
    parameter logic signed [15:0] THRESHOLD      = 16'sd100,
    parameter int                 LEAK_SHIFT     = 3,
    parameter int                 REFRACT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kill,
    input  logic [7:0]  weight,
    input  logic [6:0]  Neuron_number,
    input  logic        weight_valid,
    output logic        weight_ready,
    input  logic        tick,
    output logic        spike,
    output logic [6:0]  spike_id,
    output logic [15:0] membrane,
    output logic [1:0]  state,
    output logic [15:0] spike_count
);

    // Handshake: a weight transfers on a rising edge where weight_valid && weight_ready.
    // weight_ready depends only on rst and the state register, never on weight_valid.
    typedef enum logic [1:0] {
        ST_INTEGRATE = 2'd0,
        ST_FIRE      = 2'd1,
        ST_REFRACT   = 2'd2,
        ST_ILLEGAL   = 2'd3
    } state_t;

    localparam logic [7:0] REFRACT_LOAD =
        (REFRACT_CYCLES == 0) ? 8'd0 : 8'(REFRACT_CYCLES - 1);

    state_t             st;
    logic [7:0]         refract_cnt;
    logic signed [15:0] v;

    logic signed [16:0] sum_raw;
    logic signed [16:0] sum_clamped;
    logic signed [16:0] leaked;
    logic signed [15:0] v_next;

    // Sum is formed at 17 bits so the clamp sees the true sign and overflow.
    always_comb begin
        sum_raw = {v[15], v};
        if (weight_valid && (Neuron_number == MY_ID)) begin
            sum_raw = {v[15], v} + {{9{weight[7]}}, weight};
        end
        if (sum_raw < 17'sd0) begin
            sum_clamped = 17'sd0;
        end else if (sum_raw > 17'sd32767) begin
            sum_clamped = 17'sd32767;
        end else begin
            sum_clamped = sum_raw;
        end
        leaked = sum_clamped;
        if (tick) begin
            leaked = sum_clamped - (sum_clamped >>> LEAK_SHIFT);
        end
        v_next = leaked[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st          <= ST_INTEGRATE;
            v           <= 16'sd0;
            refract_cnt <= 8'd0;
            spike       <= 1'b0;
            spike_id    <= 7'd0;
            spike_count <= 16'd0;
        end else if (kill) begin
            st          <= ST_INTEGRATE;
            v           <= 16'sd0;
            refract_cnt <= 8'd0;
            spike       <= 1'b0;
            spike_id    <= 7'd0;
            spike_count <= 16'd0;
        end else begin
            case (st)
                ST_INTEGRATE: begin
                    v <= v_next;
                    if (v_next >= THRESHOLD) begin
                        st       <= ST_FIRE;
                        spike    <= 1'b1;
                        spike_id <= MY_ID;
                    end
                end
                ST_FIRE: begin
                    v           <= 16'sd0;
                    spike       <= 1'b0;
                    spike_id    <= 7'd0;
                    spike_count <= spike_count + 16'd1;
                    if (REFRACT_CYCLES == 0) begin
                        st <= ST_INTEGRATE;
                    end else begin
                        st          <= ST_REFRACT;
                        refract_cnt <= REFRACT_LOAD;
                    end
                end
                ST_REFRACT: begin
                    v <= 16'sd0;
                    if (refract_cnt == 8'd0) begin
                        st <= ST_INTEGRATE;
                    end else begin
                        refract_cnt <= refract_cnt - 8'd1;
                    end
                end
                default: begin
                    st          <= ST_INTEGRATE;
                    v           <= 16'sd0;
                    refract_cnt <= 8'd0;
                    spike       <= 1'b0;
                    spike_id    <= 7'd0;
                end
            endcase
        end
    end

    assign weight_ready = rst && (st != ST_FIRE);
    assign state        = st;
    assign membrane     = v;

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: directed vector table, hand-written reset/saturation sequences,
// and randomized traffic compared against an arithmetic reference model.
module tb_lif_neuron;

    logic        clk = 1'b0;
    logic        rst;
    logic        kill;
    logic [7:0]  weight;
    logic [6:0]  Neuron_number;
    logic        weight_valid;
    logic        weight_ready;
    logic        tick;
    logic        spike;
    logic [6:0]  spike_id;
    logic [15:0] membrane;
    logic [1:0]  state;
    logic [15:0] spike_count;

    logic        s_kill;
    logic [7:0]  s_weight;
    logic [6:0]  s_id;
    logic        s_valid;
    logic        s_ready;
    logic        s_tick;
    logic        s_spike;
    logic [6:0]  s_spike_id;
    logic [15:0] s_membrane;
    logic [1:0]  s_state;
    logic [15:0] s_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    lif_neuron #(.MY_ID(7'd5), .THRESHOLD(16'sd100), .LEAK_SHIFT(3), .REFRACT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .kill(kill), .weight(weight), .Neuron_number(Neuron_number),
        .weight_valid(weight_valid), .weight_ready(weight_ready), .tick(tick), .spike(spike),
        .spike_id(spike_id), .membrane(membrane), .state(state), .spike_count(spike_count)
    );

    lif_neuron #(.MY_ID(7'd5), .THRESHOLD(16'sd32767), .LEAK_SHIFT(3), .REFRACT_CYCLES(4)) dut_sat (
        .clk(clk), .rst(rst), .kill(s_kill), .weight(s_weight), .Neuron_number(s_id),
        .weight_valid(s_valid), .weight_ready(s_ready), .tick(s_tick), .spike(s_spike),
        .spike_id(s_spike_id), .membrane(s_membrane), .state(s_state), .spike_count(s_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int id, input int w, input bit t, input bit k);
        weight_valid  = v;
        Neuron_number = 7'(id);
        weight        = 8'(w);
        tick          = t;
        kill          = k;
    endtask

    task automatic check_all(input string tag, input int ev, input int est, input int ecnt);
        chk({tag, " membrane"}, int'($signed(membrane)), ev);
        chk({tag, " state"}, int'(state), est);
        chk({tag, " spike"}, int'(spike), (est == 1) ? 1 : 0);
        chk({tag, " spike_id"}, int'(spike_id), (est == 1) ? 5 : 0);
        chk({tag, " spike_count"}, int'(spike_count), ecnt);
        chk({tag, " weight_ready"}, int'(weight_ready), (est == 1) ? 0 : 1);
    endtask

    // Reference model: phase 0 integrate, 1 fire, 2 refractory with cycles remaining.
    int m_v, m_st, m_rem, m_cnt;

    task automatic model_step(input bit v, input int id, input int w, input bit t, input bit k);
        int s;
        if (k) begin
            m_v = 0; m_st = 0; m_rem = 0; m_cnt = 0;
        end else if (m_st == 0) begin
            s = m_v + ((v && id == 5) ? w : 0);
            if (s < 0) s = 0;
            if (s > 32767) s = 32767;
            if (t) s = s - s / 8;
            m_v = s;
            if (s >= 100) m_st = 1;
        end else if (m_st == 1) begin
            m_v = 0;
            m_cnt = (m_cnt + 1) % 65536;
            m_st = 2;
            m_rem = 4;
        end else begin
            m_rem--;
            if (m_rem == 0) m_st = 0;
        end
    endtask

    typedef struct {
        bit valid; int id; int w; bit tk; bit kl;
        int exp_v; int exp_st; int exp_cnt;
    } vec_t;

    vec_t vecs[24];

    initial begin
        vecs[0]  = '{1, 5,  40, 0, 0,  40, 0, 0};
        vecs[1]  = '{1, 5,  40, 0, 0,  80, 0, 0};
        vecs[2]  = '{1, 5,  30, 0, 0, 110, 1, 0};
        vecs[3]  = '{1, 5,  50, 0, 0,   0, 2, 1};
        vecs[4]  = '{1, 5,  50, 0, 0,   0, 2, 1};
        vecs[5]  = '{1, 5,  50, 1, 0,   0, 2, 1};
        vecs[6]  = '{1, 5,  50, 0, 0,   0, 2, 1};
        vecs[7]  = '{1, 5,  50, 0, 0,   0, 0, 1};
        vecs[8]  = '{1, 5,  80, 0, 0,  80, 0, 1};
        vecs[9]  = '{0, 5,   0, 1, 0,  70, 0, 1};
        vecs[10] = '{0, 5,   0, 1, 0,  62, 0, 1};
        vecs[11] = '{1, 5,   2, 0, 0,  64, 0, 1};
        vecs[12] = '{1, 5,  16, 1, 0,  70, 0, 1};
        vecs[13] = '{1, 5, -40, 0, 0,  30, 0, 1};
        vecs[14] = '{1, 6,  50, 0, 0,  30, 0, 1};
        vecs[15] = '{1, 5, -50, 0, 0,   0, 0, 1};
        vecs[16] = '{0, 5,   0, 1, 0,   0, 0, 1};
        vecs[17] = '{1, 5, 127, 0, 0, 127, 1, 1};
        vecs[18] = '{0, 5,   0, 0, 0,   0, 2, 2};
        vecs[19] = '{0, 5,   0, 0, 0,   0, 2, 2};
        vecs[20] = '{1, 5,  60, 0, 1,   0, 0, 0};
        vecs[21] = '{1, 5,  99, 0, 0,  99, 0, 0};
        vecs[22] = '{1, 5,   1, 0, 0, 100, 1, 0};
        vecs[23] = '{0, 5,   0, 0, 0,   0, 2, 1};

        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        s_kill = 1'b0; s_weight = 8'd0; s_id = 7'd0; s_valid = 1'b0; s_tick = 1'b0;

        // Reset held for two edges; ready must stay low throughout.
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("ready_in_reset", int'(weight_ready), 0);
        end
        rst = 1'b1;
        #1;
        check_all("after_reset", 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].valid, vecs[i].id, vecs[i].w, vecs[i].tk, vecs[i].kl);
            cycle();
            check_all($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_st, vecs[i].exp_cnt);
        end
        drive(0, 0, 0, 0, 0);

        // Reset in the middle of a spike aborts it without counting.
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        drive(1, 5, 100, 0, 0);
        cycle();
        chk("pre_abort state", int'(state), 1);
        chk("pre_abort spike", int'(spike), 1);
        drive(0, 0, 0, 0, 0);
        rst = 1'b0;
        cycle();
        chk("abort spike", int'(spike), 0);
        chk("abort spike_id", int'(spike_id), 0);
        chk("abort spike_count", int'(spike_count), 0);
        chk("abort state", int'(state), 0);
        chk("abort ready", int'(weight_ready), 0);
        rst = 1'b1;
        cycle();
        chk("abort count after release", int'(spike_count), 0);

        // Saturation: 258 x 127 = 32766, the next add clamps to 32767 and fires.
        s_valid = 1'b1; s_id = 7'd5; s_weight = 8'd127;
        for (int i = 0; i < 258; i++) cycle();
        chk("sat below membrane", int'($signed(s_membrane)), 32766);
        chk("sat below state", int'(s_state), 0);
        cycle();
        chk("sat clamp membrane", int'($signed(s_membrane)), 32767);
        chk("sat fire state", int'(s_state), 1);
        chk("sat fire spike", int'(s_spike), 1);
        s_valid = 1'b0;
        cycle();
        chk("sat refract state", int'(s_state), 2);
        chk("sat count", int'(s_count), 1);

        // Randomized traffic against the model, starting from a known cleared state.
        drive(0, 0, 0, 0, 1);
        cycle();
        m_v = 0; m_st = 0; m_rem = 0; m_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            bit rv, rt, rk;
            int rid, rw;
            rv  = ($urandom_range(0, 3) != 0);
            rid = ($urandom_range(0, 3) != 0) ? 5 : int'($urandom_range(0, 127));
            rw  = ($urandom_range(0, 2) != 0) ? int'($urandom_range(0, 127))
                                              : int'($urandom_range(0, 255)) - 128;
            rt  = ($urandom_range(0, 3) == 0);
            rk  = ($urandom_range(0, 79) == 0);
            drive(rv, rid, rw, rt, rk);
            model_step(rv, rid, rw, rt, rk);
            cycle();
            check_all($sformatf("rand%0d", i), m_v, m_st, m_cnt);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lif_neuron.md
LIF_NEURON -- requirements
Module: lif_neuron

Interface
REQ-001 SHALL have parameter MY_ID, default 7'd0, meaning the neuron number this instance answers to.
REQ-002 SHALL have parameter THRESHOLD, default 16'sd100, meaning the firing threshold, legal range 1..32767.
REQ-003 SHALL have parameter LEAK_SHIFT, default 3, meaning the leak is membrane >>> LEAK_SHIFT per tick, legal range 1..15.
REQ-004 SHALL have parameter REFRACT_CYCLES, default 4, meaning the refractory length in clk cycles, legal range 0..255.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 kill  input  1  synchronous soft clear, active-high.
REQ-008 weight  input  8  signed synaptic weight from the synapse stage.
REQ-009 Neuron_number  input  7  target neuron of the presented weight.
REQ-010 weight_valid  input  1  weight/Neuron_number valid.
REQ-011 weight_ready  output  1  neuron can consume a weight this cycle.
REQ-012 tick  input  1  one-cycle time-step pulse that triggers leak.
REQ-013 spike  output  1  one-cycle fire pulse.
REQ-014 spike_id  output  7  equals MY_ID while spike=1, else 0.
REQ-015 membrane  output  16  signed membrane potential V.
REQ-016 state  output  2  FSM state: 0 INTEGRATE, 1 FIRE, 2 REFRACT.
REQ-017 spike_count  output  16  number of spikes since reset/kill, wraps 65535->0.

Function
REQ-018 A transfer SHALL occur on any rising edge with weight_valid=1 and weight_ready=1.
REQ-019 weight_ready SHALL be 1 in INTEGRATE and REFRACT, and 0 in FIRE.
REQ-020 A transfer with Neuron_number!=MY_ID, or any transfer in REFRACT, SHALL be consumed without changing V.
REQ-021 In INTEGRATE, sum S = V + sign-extended weight for a matching transfer, else S = V, computed at 17 bits.
REQ-022 S SHALL be clamped to 0..32767.
REQ-023 If tick=1 in the same cycle, V_next SHALL be S - (S >>> LEAK_SHIFT), applied after the add; otherwise V_next = S.
REQ-024 V_next is visible on membrane the cycle after the transfer/tick (1-cycle latency).
REQ-025 If V_next >= THRESHOLD in INTEGRATE, state SHALL go to FIRE on that edge, with V taking V_next.
REQ-026 In FIRE (exactly one cycle): spike=1, spike_id=MY_ID.
REQ-027 On leaving FIRE: V<=0, spike_count increments, and the FSM goes to REFRACT with counter=REFRACT_CYCLES-1, or to INTEGRATE if REFRACT_CYCLES=0.
REQ-028 In REFRACT: ticks are ignored, V stays 0, and the counter decrements each cycle.
REQ-029 REFRACT SHALL go to INTEGRATE on the edge where the counter is 0, so REFRACT lasts exactly REFRACT_CYCLES cycles.
REQ-030 spike and spike_id SHALL be registered outputs derived from state, with no combinational path from inputs.
REQ-031 kill=1 SHALL on the next edge force V=0, state=INTEGRATE, counter=0, spike_count=0.
REQ-032 kill SHALL override any transfer, tick or FSM transition in that cycle; a transfer coincident with kill is consumed and discarded.
REQ-033 Illegal state encoding 3 SHALL return to INTEGRATE with V=0 on the next edge.

Reset
REQ-034 rst=0 at a rising edge SHALL set V=0, state=INTEGRATE, counter=0, spike=0, spike_id=0, spike_count=0; rst has priority over kill.
REQ-035 While rst=0, weight_ready SHALL be 0.
REQ-036 Reset asserted mid-FIRE or mid-REFRACT SHALL abort the operation with no spike_count increment.

Verification
(Parameters: MY_ID=5, THRESHOLD=100, LEAK_SHIFT=3, REFRACT_CYCLES=4.)
REQ-037 Hold rst=0 for 2 cycles, then release -> all outputs 0, weight_ready=1, state=0.
REQ-038 Fire sequence:
- Stimulus: weights 40, 40, 30 to id 5 on consecutive cycles.
- Membrane: 40, 80, 110.
- Next cycle: spike=1, spike_id=5, weight_ready=0.
- Then: V=0, spike_count=1, 4 REFRACT cycles with weight 50 to id 5 discarded, then state=0.
REQ-039 Leak: V=80, tick -> 70; tick -> 62; weight 16 with tick simultaneously at V=64 -> 70.
REQ-040 Filtering/clamp:
- Weight 50 to id 6 at V=30 -> V stays 30.
- Weight -50 to id 5 -> V=0.
- Repeated 127s saturate before firing check: from V=0 with THRESHOLD=32767, V reaches 32767 and fires.
REQ-041 Interrupts: kill in second REFRACT cycle -> next cycle state=0, V=0, spike_count=0; rst=0 during FIRE -> spike drops next cycle, spike_count unchanged at 0.
